// File: rtl/ddfs_sweep_ctrl.sv
// rtl/ddfs_sweep_ctrl.sv - linear fccw sweep sequencer with envelope attack/release
// Config is captured on an accepted start; fccw/env are registered outputs to the ddfs.
module ddfs_sweep_ctrl #(
  parameter int PW = 26,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          loop,
  input  logic [PW-1:0] f_start,
  input  logic [PW-1:0] f_stop,
  input  logic [PW-1:0] f_step,
  input  logic [DW-1:0] dwell,
  input  logic [15:0]   env_max,
  input  logic [15:0]   env_step,
  output logic [PW-1:0] fccw,
  output logic [15:0]   env,
  output logic          busy,
  output logic          step_tick,
  output logic          done
);

  typedef enum logic [1:0] {S_IDLE, S_ATTACK, S_SWEEP, S_RELEASE} state_t;

  state_t        state, state_n;
  logic [DW-1:0] dwell_cnt, cnt_n;
  logic [PW-1:0] fccw_n;
  logic [15:0]   env_n;
  logic          tick_n, done_n;

  logic [PW-1:0] f_start_r, f_stop_r, f_step_r;
  logic [DW-1:0] dwell_r;
  logic [15:0]   env_max_r, env_step_r;
  logic          loop_r, dir_up;

  logic [PW:0]   up_sum, dn_diff;
  logic [PW-1:0] up_next, dn_next;
  logic [16:0]   env_sum;
  logic [15:0]   env_up, env_dn;

  // Carry/borrow out of the word counts as overshoot, so the sweep never wraps.
  assign up_sum  = {1'b0, fccw} + {1'b0, f_step_r};
  assign dn_diff = {1'b0, fccw} - {1'b0, f_step_r};
  assign up_next = (up_sum[PW] || (up_sum[PW-1:0] > f_stop_r)) ? f_stop_r : up_sum[PW-1:0];
  assign dn_next = (dn_diff[PW] || (dn_diff[PW-1:0] < f_stop_r)) ? f_stop_r : dn_diff[PW-1:0];

  assign env_sum = {1'b0, env} + {1'b0, env_step_r};
  assign env_up  = ((env_step_r == 16'd0) || (env_sum > {1'b0, env_max_r})) ? env_max_r : env_sum[15:0];
  assign env_dn  = ((env_step_r == 16'd0) || (env_step_r >= env)) ? 16'd0 : env - env_step_r;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      fccw       <= '0;
      env        <= '0;
      dwell_cnt  <= '0;
      step_tick  <= 1'b0;
      done       <= 1'b0;
      f_start_r  <= '0;
      f_stop_r   <= '0;
      f_step_r   <= '0;
      dwell_r    <= '0;
      env_max_r  <= '0;
      env_step_r <= '0;
      loop_r     <= 1'b0;
      dir_up     <= 1'b1;
    end else begin
      state     <= state_n;
      fccw      <= fccw_n;
      env       <= env_n;
      dwell_cnt <= cnt_n;
      step_tick <= tick_n;
      done      <= done_n;
      if (state == S_IDLE && start) begin
        f_start_r  <= f_start;
        f_stop_r   <= f_stop;
        f_step_r   <= f_step;
        dwell_r    <= dwell;
        env_max_r  <= env_max;
        env_step_r <= env_step;
        loop_r     <= loop;
        dir_up     <= (f_stop >= f_start);
      end
    end
  end

  always_comb begin
    state_n = state;
    fccw_n  = fccw;
    env_n   = env;
    cnt_n   = dwell_cnt;
    tick_n  = 1'b0;
    done_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_ATTACK;
          fccw_n  = f_start;
          env_n   = 16'd0;
          cnt_n   = dwell;
        end
      end
      S_ATTACK: begin
        if (abort) begin
          state_n = S_RELEASE;
        end else if (env == env_max_r) begin
          state_n = S_SWEEP;
          cnt_n   = dwell_r;
        end else begin
          env_n = env_up;
        end
      end
      S_SWEEP: begin
        if (abort) begin
          state_n = S_RELEASE;
        end else if (dwell_cnt != '0) begin
          cnt_n = dwell_cnt - 1'b1;
        end else if (fccw != f_stop_r) begin
          // A zero step parks the word at f_start; only abort leaves.
          cnt_n = dwell_r;
          if (f_step_r != '0) begin
            fccw_n = dir_up ? up_next : dn_next;
            tick_n = 1'b1;
          end
        end else if (loop_r) begin
          fccw_n = f_start_r;
          tick_n = 1'b1;
          cnt_n  = dwell_r;
        end else begin
          state_n = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (env == 16'd0) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else begin
          env_n = env_dn;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ddfs_sweep_ctrl.sv
// tb/tb_ddfs_sweep_ctrl.sv - directed and random checks of ddfs_sweep_ctrl against a behavioural model
// The model tracks the sweep phase and evaluates clamps with plain integer arithmetic.
module tb_ddfs_sweep_ctrl;
  localparam int PW = 26;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0, abort = 1'b0, loop = 1'b0;
  logic [PW-1:0] f_start = '0, f_stop = '0, f_step = '0;
  logic [DW-1:0] dwell = '0;
  logic [15:0]   env_max = '0, env_step = '0;
  logic [PW-1:0] fccw;
  logic [15:0]   env;
  logic          busy, step_tick, done;

  int checks = 0;
  int errors = 0;

  ddfs_sweep_ctrl #(.PW(PW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .loop(loop),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
    .env_max(env_max), .env_step(env_step), .fccw(fccw), .env(env),
    .busy(busy), .step_tick(step_tick), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_q(input string name, input longint got[$], input longint exp[$]);
    bit ok;
    string s;
    checks++;
    ok = (got.size() == exp.size());
    for (int i = 0; ok && i < got.size(); i++) if (got[i] != exp[i]) ok = 0;
    if (!ok) begin
      errors++;
      s = "";
      for (int i = 0; i < got.size() && i < 12; i++) s = {s, $sformatf("%0d ", got[i])};
      $display("FAIL %s got [ %s] (%0d items) expected %0d items starting %0d", name, s,
               got.size(), exp.size(), (exp.size() > 0) ? exp[0] : -1);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 attack, 2 sweep, 3 release.
  int     m_phase;
  longint m_fccw, m_cnt;
  int     m_env;
  bit     m_tick, m_done;
  longint c_start, c_stop, c_step, c_dwell;
  int     c_emax, c_estep;
  bit     c_loop;

  function automatic longint next_freq(input longint f, input longint stop_w,
                                       input longint stp, input longint start_w);
    longint n;
    if (stop_w >= start_w) begin
      n = f + stp;
      if (n > stop_w) n = stop_w;
    end else begin
      n = f - stp;
      if (n < stop_w) n = stop_w;
    end
    return n;
  endfunction

  function automatic int attack_env(input int e, input int mx, input int st);
    if (st == 0 || e + st > mx) return mx;
    return e + st;
  endfunction

  function automatic int release_env(input int e, input int st);
    if (st == 0 || e <= st) return 0;
    return e - st;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase <= 0; m_fccw <= 0; m_env <= 0; m_cnt <= 0; m_tick <= 0; m_done <= 0;
    end else begin
      m_tick <= 0;
      m_done <= 0;
      case (m_phase)
        0: if (start) begin
          c_start <= f_start; c_stop <= f_stop; c_step <= f_step; c_dwell <= dwell;
          c_emax <= int'(env_max); c_estep <= int'(env_step); c_loop <= loop;
          m_fccw <= f_start; m_env <= 0; m_cnt <= dwell; m_phase <= 1;
        end
        1: if (abort) m_phase <= 3;
           else if (m_env == c_emax) begin m_phase <= 2; m_cnt <= c_dwell; end
           else m_env <= attack_env(m_env, c_emax, c_estep);
        2: if (abort) m_phase <= 3;
           else if (m_cnt > 0) m_cnt <= m_cnt - 1;
           else if (m_fccw != c_stop) begin
             m_cnt <= c_dwell;
             if (c_step != 0) begin
               m_fccw <= next_freq(m_fccw, c_stop, c_step, c_start);
               m_tick <= 1;
             end
           end else if (c_loop) begin
             m_fccw <= c_start; m_tick <= 1; m_cnt <= c_dwell;
           end else m_phase <= 3;
        default: if (m_env == 0) begin m_phase <= 0; m_done <= 1; end
                 else m_env <= release_env(m_env, c_estep);
      endcase
    end
  end

  always @(negedge clk) begin
    chk("fccw", fccw, m_fccw);
    chk("env", env, m_env);
    chk("busy", busy, m_phase != 0);
    chk("step_tick", step_tick, m_tick);
    chk("done", done, m_done);
  end

  longint fq[$], eq[$], rl[$], exp[$], sub[$];
  int ticks, dones;

  task automatic do_start(input longint fs, input longint fe, input longint fst,
                          input int dw, input int em, input int es, input bit lp);
    f_start = fs[PW-1:0]; f_stop = fe[PW-1:0]; f_step = fst[PW-1:0];
    dwell = dw[DW-1:0]; env_max = em[15:0]; env_step = es[15:0]; loop = lp;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic capture(input int abort_at, input int restart_at, input int budget);
    fq.delete(); eq.delete(); rl.delete(); ticks = 0; dones = 0;
    for (int c = 0; c < budget; c++) begin
      if (fq.size() == 0 || fq[fq.size()-1] != longint'(fccw)) begin
        fq.push_back(fccw); rl.push_back(1);
      end else rl[rl.size()-1] = rl[rl.size()-1] + 1;
      if (eq.size() == 0 || eq[eq.size()-1] != longint'(env)) eq.push_back(env);
      ticks += int'(step_tick);
      dones += int'(done);
      if (done) break;
      abort = (c == abort_at);
      start = (c == restart_at);
      if (c == restart_at) begin f_start = 500; f_stop = 900; f_step = 1; end
      @(negedge clk);
    end
    abort = 0; start = 0;
    chk("capture_done_seen", dones, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_fccw", fccw, 0);
    chk("reset_busy", busy, 0);
    @(negedge clk);

    do_start(100, 130, 10, 2, 8, 4, 0);
    capture(-1, -1, 200);
    exp = '{100, 110, 120, 130}; chk_q("t1_fccw", fq, exp);
    exp = '{0, 4, 8, 4, 0};      chk_q("t1_env", eq, exp);
    chk("t1_ticks", ticks, 3);
    chk("t1_hold110", (rl.size() > 1) ? rl[1] : -1, 3);
    @(negedge clk);

    do_start(0, 25, 10, 0, 1, 1, 0);
    capture(-1, -1, 100);
    exp = '{0, 10, 20, 25}; chk_q("t2_up_clamp", fq, exp);
    do_start(25, 0, 10, 0, 1, 1, 0);
    capture(-1, -1, 100);
    exp = '{25, 15, 5, 0}; chk_q("t2_dn_clamp", fq, exp);
    do_start(33554433, 67108863, 33554432, 1, 2, 1, 0);
    capture(-1, -1, 100);
    exp = '{33554433, 67108863}; chk_q("t2_top_carry", fq, exp);
    do_start(5, 0, 33554432, 0, 2, 1, 0);
    capture(-1, -1, 100);
    exp = '{5, 0}; chk_q("t2_bottom_borrow", fq, exp);

    do_start(100, 120, 10, 0, 4, 4, 1);
    capture(15, -1, 100);
    sub = (fq.size() >= 6) ? fq[0:5] : fq;
    exp = '{100, 110, 120, 100, 110, 120}; chk_q("t3_loop", sub, exp);

    do_start(700, 900, 10, 0, 8, 4, 0);
    capture(1, -1, 100);
    exp = '{0, 4, 0}; chk_q("t4_abort_env", eq, exp);
    exp = '{700};     chk_q("t4_fccw_hold", fq, exp);
    chk("t4_ticks", ticks, 0);

    do_start(100, 130, 10, 2, 8, 4, 0);
    capture(-1, 5, 200);
    exp = '{100, 110, 120, 130}; chk_q("t5_restart_ignored", fq, exp);
    @(negedge clk);
    f_start = 40; f_stop = 40; f_step = 0; dwell = 0; env_max = 3; env_step = 0; loop = 0;
    start = 1; abort = 1;
    @(negedge clk);
    start = 0; abort = 0;
    chk("t5_start_beats_abort", busy, 1);
    capture(-1, -1, 50);

    do_start(100, 100, 0, 0, 8, 0, 0);
    capture(-1, -1, 50);
    exp = '{0, 8, 0}; chk_q("t6_env_jump", eq, exp);
    do_start(100, 130, 10, 2, 8, 4, 0);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_fccw", fccw, 0);
    chk("t6_rst_env", env, 0);
    chk("t6_rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (6) begin @(negedge clk); dones += int'(done); end
    chk("t6_no_done", dones, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        f_start = 67108863 - $urandom_range(0, 300);
        f_stop  = 67108863 - $urandom_range(0, 300);
        f_step  = $urandom_range(1, 3) << 23;
      end else begin
        f_start = $urandom_range(0, 300);
        f_stop  = $urandom_range(0, 300);
        f_step  = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 60);
      end
      dwell    = $urandom_range(0, 3);
      env_max  = $urandom_range(0, 40);
      env_step = $urandom_range(0, 20);
      loop     = ($urandom_range(0, 5) == 0);
      start    = ($urandom_range(0, 15) == 0);
      abort    = ($urandom_range(0, 40) == 0);
      reset    = ($urandom_range(0, 600) == 0);
      @(negedge clk);
    end
    reset = 0; start = 0; abort = 0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
